motoro3_commutator: RTL

Parametrised six-step commutation driver for the 3-phase motor path. It generates the six gate signals from a start level, a 2-bit mode and a frequency word, using a phase accumulator in place of a divider. Every turn-on is guarded by a programmable dead time, and the block supports forward run, reverse run, coast and brake. It sits between the motor-control register interface and the gate-driver pins, and replaces the fixed 3-phase driver of the previous generation.

---
 rtl/motoro3_commutator_if.sv | 27 ++
 rtl/motoro3_commutator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/motoro3_commutator_if.sv
// Control and gate-drive bundle between the motor register block,
// the six-step commutator and the gate-driver pins.
interface motoro3_commutator_if #(
    parameter int FREQ_W = 10
);
    logic              m3start;
    logic [1:0]        m3mode;
    logic [FREQ_W-1:0] m3freq;
    logic              aH;
    logic              aL;
    logic              bH;
    logic              bL;
    logic              cH;
    logic              cL;
    logic [2:0]        m3step;
    logic              m3stepPulse;

    modport master (
        output m3start, m3mode, m3freq,
        input  aH, aL, bH, bL, cH, cL, m3step, m3stepPulse
    );

    modport slave (
        input  m3start, m3mode, m3freq,
        output aH, aL, bH, bL, cH, cL, m3step, m3stepPulse
    );
endinterface

// File: rtl/motoro3_commutator.sv
// Six-step 3-phase commutator: phase-accumulator step timing and
// dead-time guarded gate register.
module motoro3_commutator #(
    parameter int CLK_HZ   = 10_000_000,
    parameter int FREQ_W   = 10,
    parameter int DEAD_CYC = 8,
    parameter int ACC_W    = 24
) (
    input logic                 clk,
    input logic                 nRst,
    motoro3_commutator_if.slave m3
);
    localparam logic [ACC_W-1:0] LP_MOD  = ACC_W'(CLK_HZ);
    localparam logic [ACC_W-1:0] LP_SIX  = ACC_W'(6);
    localparam logic [7:0]       LP_DEAD = 8'(DEAD_CYC);

    // gate vector order: {aH, aL, bH, bL, cH, cL}
    localparam logic [5:0] LP_BRAKE = 6'b010101;

    logic             r_start;
    logic [1:0]       r_mode;
    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_step;
    logic             r_pulse;
    logic [5:0]       r_tgt;
    logic [5:0]       r_gate;
    logic [7:0]       r_dc;

    logic             w_run;
    logic             w_cross;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_nx;
    logic [2:0]       w_step_nx;
    logic [5:0]       w_tgt;
    logic [5:0]       w_on;
    logic [5:0]       w_gate_nx;
    logic [7:0]       w_dc_nx;

    assign w_run   = r_start & ~r_mode[1];
    assign w_sum   = r_acc + ACC_W'(m3.m3freq) * LP_SIX;
    assign w_cross = (w_sum >= LP_MOD);

    always_comb begin
        w_acc_nx  = r_acc;
        w_step_nx = r_step;
        if (!r_start) begin
            w_acc_nx  = '0;
            w_step_nx = '0;
        end else if (w_run) begin
            if (w_cross) begin
                w_acc_nx = w_sum - LP_MOD;
                if (r_mode[0]) begin
                    w_step_nx = (r_step == 3'd0) ? 3'd5 : r_step - 3'd1;
                end else begin
                    w_step_nx = (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
                end
            end else begin
                w_acc_nx = w_sum;
            end
        end
    end

    always_comb begin
        w_tgt = '0;
        if (r_start && r_mode == 2'b11) begin
            w_tgt = LP_BRAKE;
        end else if (w_run) begin
            unique case (r_step)
                3'd0:    w_tgt = 6'b100100;
                3'd1:    w_tgt = 6'b100001;
                3'd2:    w_tgt = 6'b001001;
                3'd3:    w_tgt = 6'b011000;
                3'd4:    w_tgt = 6'b010010;
                3'd5:    w_tgt = 6'b000110;
                default: w_tgt = '0;
            endcase
        end
    end

    // New target: drop turn-offs now, then hold turn-ons for DEAD_CYC.
    assign w_on = w_tgt & ~r_gate;

    always_comb begin
        w_gate_nx = r_gate;
        w_dc_nx   = r_dc;
        if (w_tgt != r_tgt) begin
            w_gate_nx = r_gate & w_tgt;
            w_dc_nx   = (|w_on) ? LP_DEAD : 8'd0;
        end else if (r_gate != w_tgt) begin
            if (r_dc <= 8'd1) begin
                w_gate_nx = w_tgt;
                w_dc_nx   = 8'd0;
            end else begin
                w_dc_nx = r_dc - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_start <= 1'b0;
            r_mode  <= 2'b00;
            r_acc   <= '0;
            r_step  <= 3'd0;
            r_pulse <= 1'b0;
            r_tgt   <= '0;
            r_gate  <= '0;
            r_dc    <= 8'd0;
        end else begin
            r_start <= m3.m3start;
            r_mode  <= m3.m3mode;
            r_acc   <= w_acc_nx;
            r_step  <= w_step_nx;
            r_pulse <= (w_step_nx != r_step);
            r_tgt   <= w_tgt;
            r_gate  <= w_gate_nx;
            r_dc    <= w_dc_nx;
        end
    end

    assign m3.aH          = r_gate[5];
    assign m3.aL          = r_gate[4];
    assign m3.bH          = r_gate[3];
    assign m3.bL          = r_gate[2];
    assign m3.cH          = r_gate[1];
    assign m3.cL          = r_gate[0];
    assign m3.m3step      = r_step;
    assign m3.m3stepPulse = r_pulse;
endmodule
